// File: rtl/pre_norm_mul_seq.sv
// -----------------------------------------------------------------------------
// pre_norm_mul_seq
//
// Multi-cycle front end of the single-precision FP multiplier. It accepts two
// IEEE-754 operands over a valid/ready handshake and unpacks them. It then
// produces the result sign, the biased exponent sum with range flags,
// infinity/NaN indications and the full 48-bit mantissa product. The product
// comes from a radix-2 shift-add loop (one multiplier bit per cycle). Every
// output is driven from a register, so the result bundle is held stable until
// downstream takes it.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : operand bundle valid
//   in_ready_o   : block idle and able to accept operands
//   opa_i, opb_i : IEEE-754 single operands
//   rmode_i      : rounding mode, forwarded unchanged
//   out_valid_o  : result bundle valid
//   out_ready_i  : downstream accepts result
//   opa_o, opb_o : captured operands
//   rmode_o      : captured rounding mode
//   sign_o       : product sign
//   exp_10_o     : low 8 bits of the exponent sum
//   exp_ovf_o    : 2'b11 exponent above 255, 2'b10 below 0, else 2'b00
//   fract_48_o   : unsigned 24x24 mantissa product
//   inf_o        : either operand is infinity
//   nan_o        : either operand is NaN
// -----------------------------------------------------------------------------
module pre_norm_mul_seq #(
    parameter int MUL_ITER = 24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [1:0]  rmode_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] opa_o,
    output logic [31:0] opb_o,
    output logic [1:0]  rmode_o,
    output logic        sign_o,
    output logic [7:0]  exp_10_o,
    output logic [1:0]  exp_ovf_o,
    output logic [47:0] fract_48_o,
    output logic        inf_o,
    output logic        nan_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    // Mantissa with hidden bit; the hidden bit is 0 for denormals and zero.
    function automatic logic [23:0] unpack_mant(input logic [31:0] op);
        return {(op[30:23] != 8'd0), op[22:0]};
    endfunction

    // Effective exponent: denormals behave as if their exponent field were 1.
    function automatic logic [9:0] eff_exp(input logic [31:0] op);
        return (op[30:23] == 8'd0) ? 10'd1 : {2'b00, op[30:23]};
    endfunction

    function automatic logic is_zero(input logic [31:0] op);
        return (op[30:23] == 8'd0) && (op[22:0] == 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] op);
        return (op[30:23] == 8'hFF) && (op[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] op);
        return (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
    endfunction

    logic [1:0]  state_q,     state_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] opa_q,       opa_d;
    logic [31:0] opb_q,       opb_d;
    logic [1:0]  rmode_q,     rmode_d;
    logic        sign_q,      sign_d;
    logic [7:0]  exp_q,       exp_d;
    logic [1:0]  ovf_q,       ovf_d;
    logic        inf_q,       inf_d;
    logic        nan_q,       nan_d;
    logic [47:0] acc_q,       acc_d;
    logic [47:0] mcand_q,     mcand_d;
    logic [23:0] mplier_q,    mplier_d;
    logic [4:0]  cnt_q,       cnt_d;

    logic [9:0]  exp_sum_s;
    logic [1:0]  exp_ovf_s;

    // Ten-bit two's complement exponent sum of the incoming operands.
    always_comb begin
        exp_sum_s = eff_exp(opa_i) + eff_exp(opb_i) - 10'd127;
        if (exp_sum_s[9]) begin
            exp_ovf_s = 2'b10;
        end else if (exp_sum_s[8]) begin
            exp_ovf_s = 2'b11;
        end else begin
            exp_ovf_s = 2'b00;
        end
    end

    // Next-state logic: accept/unpack, shift-add iteration, result hold.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rmode_d  = rmode_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        ovf_d    = ovf_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    opa_d    = opa_i;
                    opb_d    = opb_i;
                    rmode_d  = rmode_i;
                    sign_d   = opa_i[31] ^ opb_i[31];
                    exp_d    = exp_sum_s[7:0];
                    ovf_d    = exp_ovf_s;
                    inf_d    = is_inf(opa_i) | is_inf(opb_i);
                    nan_d    = is_nan(opa_i) | is_nan(opb_i);
                    acc_d    = 48'd0;
                    mcand_d  = {24'd0, unpack_mant(opa_i)};
                    mplier_d = unpack_mant(opb_i);
                    cnt_d    = 5'd0;
                    // A zero operand makes the product zero; skip the loop.
                    if (is_zero(opa_i) || is_zero(opb_i)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[46:0], 1'b0};
                mplier_d = {1'b0, mplier_q[23:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered from the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            rmode_q     <= 2'd0;
            sign_q      <= 1'b0;
            exp_q       <= 8'd0;
            ovf_q       <= 2'd0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            acc_q       <= 48'd0;
            mcand_q     <= 48'd0;
            mplier_q    <= 24'd0;
            cnt_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rmode_q     <= rmode_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            ovf_q       <= ovf_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign opa_o       = opa_q;
    assign opb_o       = opb_q;
    assign rmode_o     = rmode_q;
    assign sign_o      = sign_q;
    assign exp_10_o    = exp_q;
    assign exp_ovf_o   = ovf_q;
    assign fract_48_o  = acc_q;
    assign inf_o       = inf_q;
    assign nan_o       = nan_q;

endmodule

// File: tb/tb_pre_norm_mul_seq.sv
module tb_pre_norm_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic [1:0]  rmode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] opa_o;
    logic [31:0] opb_o;
    logic [1:0]  rmode_o;
    logic        sign_o;
    logic [7:0]  exp_10_o;
    logic [1:0]  exp_ovf_o;
    logic [47:0] fract_48_o;
    logic        inf_o;
    logic        nan_o;

    int vectors     = 0;
    int miscompares = 0;

    // Snapshot of the last result, taken from the DUT when out_valid_o rose.
    logic [47:0] snap_fract;
    logic [7:0]  snap_exp;
    logic [1:0]  snap_ovf;
    logic        snap_sign;
    logic        snap_inf;
    logic        snap_nan;

    pre_norm_mul_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opa_i       (opa_i),
        .opb_i       (opb_i),
        .rmode_i     (rmode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .opa_o       (opa_o),
        .opb_o       (opb_o),
        .rmode_o     (rmode_o),
        .sign_o      (sign_o),
        .exp_10_o    (exp_10_o),
        .exp_ovf_o   (exp_ovf_o),
        .fract_48_o  (fract_48_o),
        .inf_o       (inf_o),
        .nan_o       (nan_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model written from the numeric rules with plain integers.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic m_sign, output logic [7:0] m_exp,
                         output logic [1:0] m_ovf, output logic [47:0] m_fract,
                         output logic m_inf, output logic m_nan, output logic m_zero);
        int     ea, eb, s;
        longint ma, mb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        mb = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        s  = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
        m_sign  = a[31] ^ b[31];
        m_exp   = 8'(s);
        m_ovf   = (s < 0) ? 2'b10 : ((s > 255) ? 2'b11 : 2'b00);
        m_fract = 48'(ma * mb);
        m_inf   = (ea == 255 && a[22:0] == 23'd0) || (eb == 255 && b[22:0] == 23'd0);
        m_nan   = (ea == 255 && a[22:0] != 23'd0) || (eb == 255 && b[22:0] != 23'd0);
        m_zero  = (ma == 0) || (mb == 0);
    endtask

    // One full transaction: accept, wait, compare, optional backpressure, handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input int hold);
        logic        m_sign, m_inf, m_nan, m_zero;
        logic [7:0]  m_exp;
        logic [1:0]  m_ovf;
        logic [47:0] m_fract;
        int          lat;
        model(a, b, m_sign, m_exp, m_ovf, m_fract, m_inf, m_nan, m_zero);
        check("ready_before_accept", 64'(in_ready_o), 64'd1);
        opa_i      = a;
        opb_i      = b;
        rmode_i    = rm;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 64'(lat), m_zero ? 64'd1 : 64'd25);
        check("fract_48", 64'(fract_48_o), 64'(m_fract));
        check("exp_10", 64'(exp_10_o), 64'(m_exp));
        check("exp_ovf", 64'(exp_ovf_o), 64'(m_ovf));
        check("sign", 64'(sign_o), 64'(m_sign));
        check("inf", 64'(inf_o), 64'(m_inf));
        check("nan", 64'(nan_o), 64'(m_nan));
        check("opa_o", 64'(opa_o), 64'(a));
        check("opb_o", 64'(opb_o), 64'(b));
        check("rmode_o", 64'(rmode_o), 64'(rm));
        check("ready_while_done", 64'(in_ready_o), 64'd0);
        snap_fract = fract_48_o;
        snap_exp   = exp_10_o;
        snap_ovf   = exp_ovf_o;
        snap_sign  = sign_o;
        snap_inf   = inf_o;
        snap_nan   = nan_o;
        // Backpressure: a competing bundle is offered and must be ignored.
        for (int i = 0; i < hold; i++) begin
            opa_i      = 32'h3F800000;
            opb_i      = 32'h3F800000;
            in_valid_i = 1'b1;
            @(posedge clk_i); #1;
            check("hold_valid", 64'(out_valid_o), 64'd1);
            check("hold_ready", 64'(in_ready_o), 64'd0);
            check("hold_fract", 64'(fract_48_o), 64'(m_fract));
            check("hold_opa", 64'(opa_o), 64'(a));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        check("post_hs_valid", 64'(out_valid_o), 64'd0);
        check("post_hs_ready", 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        opa_i       = 32'd0;
        opb_i       = 32'd0;
        rmode_i     = 2'd0;
        #12;
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_fract", 64'(fract_48_o), 64'd0);
        check("rst_opa", 64'(opa_o), 64'd0);
        check("rst_flags", 64'({exp_ovf_o, inf_o, nan_o, sign_o, rmode_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Normal products.
        run_op(32'h3FC00000, 32'h40000000, 2'd1, 0);
        check("tp_norm_fract", 64'(snap_fract), 64'h600000000000);
        check("tp_norm_exp", 64'(snap_exp), 64'h80);
        check("tp_norm_sign", 64'(snap_sign), 64'd0);
        run_op(32'hBFC00000, 32'h40000000, 2'd2, 0);
        check("tp_neg_sign", 64'(snap_sign), 64'd1);

        // Zero short-circuit.
        run_op(32'h00000000, 32'h40490FDB, 2'd3, 0);
        check("tp_zero_fract", 64'(snap_fract), 64'd0);
        check("tp_zero_exp", 64'(snap_exp), 64'h02);

        // Exponent range.
        run_op(32'h7F000000, 32'h7F000000, 2'd0, 0);
        check("tp_ovf", 64'(snap_ovf), 64'b11);
        check("tp_ovf_exp", 64'(snap_exp), 64'h7D);
        check("tp_ovf_fract", 64'(snap_fract), 64'h400000000000);
        run_op(32'h00800000, 32'h00800000, 2'd0, 0);
        check("tp_unf", 64'(snap_ovf), 64'b10);
        check("tp_unf_exp", 64'(snap_exp), 64'h83);

        // Denormal.
        run_op(32'h00000001, 32'h3F800000, 2'd0, 0);
        check("tp_den_fract", 64'(snap_fract), 64'h000000800000);
        check("tp_den_exp", 64'(snap_exp), 64'h01);

        // Specials, with backpressure on the infinity case.
        run_op(32'h7F800000, 32'h3F800000, 2'd0, 10);
        check("tp_inf", 64'({snap_inf, snap_nan}), 64'b10);
        run_op(32'h7FC00000, 32'h12345678, 2'd1, 0);
        check("tp_nan", 64'(snap_nan), 64'd1);
        // Nothing was accepted during backpressure.
        repeat (2) @(posedge clk_i);
        #1;
        check("no_spurious", 64'(out_valid_o), 64'd0);

        // Reset during MUL discards the operation.
        opa_i      = 32'h3FC00000;
        opb_i      = 32'h40000000;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_ready", 64'(in_ready_o), 64'd1);
        check("mid_rst_fract", 64'(fract_48_o), 64'd0);
        check("mid_rst_ops", 64'({opa_o, opb_o}), 64'd0);
        check("mid_rst_exp", 64'({exp_10_o, exp_ovf_o, sign_o, inf_o, nan_o, rmode_o}), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_op(32'h3FC00000, 32'h40000000, 2'd0, 0);
        check("after_rst_fract", 64'(snap_fract), 64'h600000000000);

        // Randomized operands, biased toward zero, denormal and special fields.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra[30:0] = 31'd0;
                1: ra[30:23] = 8'd0;
                2: rb[30:23] = 8'd0;
                3: rb[30:23] = 8'hFF;
                4: begin ra[30:23] = 8'd1; rb[30:23] = 8'd2; end
                5: begin ra[22:0] = 23'h7FFFFF; rb[22:0] = 23'h7FFFFF; end
                default: ra = ra;
            endcase
            run_op(ra, rb, 2'($urandom_range(0, 3)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pre_norm_mul_seq.md
# pre_norm_mul_seq

Multi-cycle multiplier front end for the floating-point unit. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and unpacks them. It then computes the sign, the biased exponent with over/underflow flags, and the full 48-bit mantissa product using an iterative radix-2 shift-add. The outputs are registered and feed post-normalization/rounding directly: `exp_10`, `fract_48`, `exp_ovf`, `sign`, plus the captured operands and rounding mode.

## Interface
- `MUL_ITER`, 24: shift-add iterations, one per multiplier bit. Fixed at 24 for single precision and not meant to be overridden.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `in_valid_i` input 1: operand bundle valid.
- `in_ready_o` output 1: block can accept operands.
- `opa_i` input 32: operand A, IEEE-754 single.
- `opb_i` input 32: operand B, IEEE-754 single.
- `rmode_i` input 2: rounding mode, captured and forwarded unchanged.
- `out_valid_o` output 1: result bundle valid.
- `out_ready_i` input 1: downstream accepts result.
- `opa_o`, `opb_o` output 32 each: captured operands, forwarded for the zero and denormal checks in post-normalization.
- `rmode_o` output 2: captured rounding mode.
- `sign_o` output 1: `opa[31] ^ opb[31]`.
- `exp_10_o` output 8: low 8 bits of the exponent sum S.
- `exp_ovf_o` output 2: exponent range flags.
- `fract_48_o` output 48: unsigned 24x24 mantissa product.
- `inf_o` output 1: either operand has exponent 0xFF and fraction 0.
- `nan_o` output 1: either operand has exponent 0xFF and fraction nonzero.

## Operation
- States: IDLE, MUL, DONE.
- `in_ready_o` = 1 only in IDLE.
- **Accept.** An accept is `in_valid_i & in_ready_o` on a rising edge. On accept, the block registers the operands and `rmode`, then:
  - Mantissa: `{hidden, frac}`, where hidden = 1 if exp ≠ 0, else 0 (denormal).
  - Effective exponent: the field value, or 1 when the field is 0.
  - S: 10-bit two's complement, `S = ea_eff + eb_eff - 127`.
  - `exp_ovf`: 2'b11 if 255 < S (S[9]=0, S[8]=1); 2'b10 if S < 0 (S[9]=1); else 2'b00. 2'b01 is never produced.
  - `exp_10_o` = S[7:0] in all cases.
  - `sign_o`, `inf_o` and `nan_o` are computed from the captured operands.
  - If either operand is zero (exp = 0 and frac = 0): `fract_48` = 0 and the next state is DONE (multiply skipped).
  - Otherwise: clear the 48-bit accumulator, load a multiplier shift register with B's mantissa and a 48-bit multiplicand with A's mantissa zero-extended, clear the iteration counter, and go to MUL.
- **MUL.** Each cycle:
  - If multiplier LSB = 1: acc += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter += 1.
  - After the 24th iteration (counter == 23 in that cycle), go to DONE.
  - The accumulator never overflows 48 bits: the maximum product is (2^24 - 1)^2.
- **DONE.** `out_valid_o` = 1 and all outputs are held stable. When `out_ready_i` = 1, go to IDLE.
- NaN/Inf operands are multiplied like normal operands. Special-case resolution belongs to post-normalization using `inf_o` / `nan_o`.

## Timing
- **Reset** (asynchronous, `rst_ni` low): state IDLE; `in_ready_o` = 1; `out_valid_o` = 0. All data outputs, `opa_o`, `opb_o`, `rmode_o`, `exp_ovf_o`, `inf_o`, `nan_o`, the accumulator and the counter = 0.
- **Reset mid-operation:** the in-flight operation is discarded with no output.
- **Latency**, for an accept at edge T:
  - Nonzero operands: MUL occupies edges T+1..T+24 and `out_valid_o` rises after edge T+24 (25 cycles from accept).
  - Zero operand: `out_valid_o` rises after edge T (1 cycle).
- **Output handshake:** the result completes on the first edge with `out_valid_o & out_ready_i`. `in_ready_o` rises after that edge; the accept at that same edge is not possible. Throughput is one result per 26 cycles (nonzero) or 2 cycles (zero).
- `in_valid_i` outside IDLE is ignored; upstream must hold its bundle stable until accepted.
- Outputs are stable from `out_valid_o` rise until the handshake. `out_ready_i` may be held high permanently.

## Test plan
- **Normal product:** `opa_i` = 0x3FC00000 (1.5), `opb_i` = 0x40000000 (2.0) → after 25 cycles: `fract_48_o` = 0x600000000000, `exp_10_o` = 0x80, `exp_ovf_o` = 00, `sign_o` = 0. Repeat with `opa_i` = 0xBFC00000 → `sign_o` = 1.
- **Zero short-circuit:** `opa_i` = 0x00000000, `opb_i` = 0x40490FDB → `out_valid_o` one cycle after accept, `fract_48_o` = 0, `exp_10_o` = 0x02, `exp_ovf_o` = 00.
- **Overflow and underflow:**
  - 0x7F000000 × 0x7F000000 → S = 381, `exp_ovf_o` = 11, `exp_10_o` = 0x7D, `fract_48_o` = 0x400000000000.
  - 0x00800000 × 0x00800000 → S = -125, `exp_ovf_o` = 10, `exp_10_o` = 0x83.
- **Denormal:** 0x00000001 × 0x3F800000 → `fract_48_o` = 0x000000800000, `exp_10_o` = 0x01, `exp_ovf_o` = 00.
- **Specials and backpressure:**
  - 0x7F800000 × 0x3F800000 → `inf_o` = 1, `nan_o` = 0. 0x7FC00000 × any → `nan_o` = 1.
  - Hold `out_ready_i` = 0 for 10 cycles after `out_valid_o`: outputs remain stable, `in_ready_o` = 0, and a new `in_valid_i` is not accepted.
- **Reset mid-MUL:** drop `rst_ni` at cycle 12 of MUL → `out_valid_o` = 0 and all outputs 0 immediately. After release, a fresh 1.5 × 2.0 operation completes correctly.
